// File: rtl/regset_pkg.sv
// Shared types and helpers for the parametrised register file.
package regset_pkg;

    typedef enum logic {CLEAR, RUN} regset_state_t;

    localparam int DATA_W_DEF   = 32;
    localparam int ADDR_W_DEF   = 5;
    localparam int PORT_BUS_MAX = 256;
    localparam int FIELD_MAX    = 64;

    // Port k of a packed multi-port bus; the caller truncates to the field width.
    function automatic logic [FIELD_MAX-1:0] port_field(
        input logic [PORT_BUS_MAX-1:0] packed_bus,
        input int                      k,
        input int                      width
    );
        return FIELD_MAX'(packed_bus >> (k * width));
    endfunction

endpackage

// File: rtl/regset_if.sv
// Write port, packed read ports and ready flag between the core and the register file.
interface regset_if
    import regset_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int N_READ = 2
);
    logic                     write_enable;
    logic [ADDR_W-1:0]        write_addr;
    logic [DATA_W-1:0]        write_data;
    logic [N_READ*ADDR_W-1:0] read_addr;
    logic [N_READ*DATA_W-1:0] read_data;
    logic                     ready;

    modport master (
        output write_enable, write_addr, write_data, read_addr,
        input  read_data, ready
    );

    modport slave (
        input  write_enable, write_addr, write_data, read_addr,
        output read_data, ready
    );
endinterface

// File: rtl/regset_clear_seq.sv
// Post-reset clear sequencer: walks indices 1..2**ADDR_W-1, then raises ready.
//   state | meaning
//   CLEAR | zeroing register clr_idx each edge; ready low
//   RUN   | clear done; ready high, port writes accepted
module regset_clear_seq
    import regset_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_idx,
    output logic              ready
);
    localparam logic [ADDR_W-1:0] IDX_FIRST = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] IDX_LAST  = '1;

    regset_state_t     r_state;
    regset_state_t     w_state_nxt;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] w_idx_nxt;
    logic              r_ready;
    logic              w_ready_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= CLEAR;
            r_idx   <= IDX_FIRST;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_ready <= w_ready_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_ready_nxt = r_ready;
        clr_we      = 1'b0;
        case (r_state)
            CLEAR: begin
                // Storage must stay untouched on a reset edge.
                clr_we = !reset;
                if (r_idx == IDX_LAST) begin
                    w_state_nxt = RUN;
                    w_ready_nxt = 1'b1;
                end else begin
                    w_idx_nxt = r_idx + IDX_FIRST;
                end
            end
            RUN: begin
                w_ready_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = CLEAR;
            end
        endcase
    end

    assign clr_idx = r_idx;
    assign ready   = r_ready;

endmodule

// File: rtl/regset_param.sv
// Register file with x0 hardwired to zero, N_READ combinational read ports,
// optional write-to-read bypass and a hardware clear after reset.
module regset_param
    import regset_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int N_READ = 2,
    parameter bit BYPASS = 1'b1
) (
    input logic     clk,
    input logic     reset,
    regset_if.slave bus
);
    localparam int N_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_regs [1:N_REGS-1];
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_idx;
    logic              w_ready;
    logic              w_port_we;

    regset_clear_seq #(.ADDR_W(ADDR_W)) u_clear_seq (
        .clk    (clk),
        .reset  (reset),
        .clr_we (w_clr_we),
        .clr_idx(w_clr_idx),
        .ready  (w_ready)
    );

    // ready is high exactly in RUN, so it gates port writes; reset wins over a write.
    assign w_port_we = w_ready && !reset && bus.write_enable && (bus.write_addr != '0);

    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_regs[w_clr_idx] <= '0;
        end else if (w_port_we) begin
            r_regs[bus.write_addr] <= bus.write_data;
        end
    end

    for (genvar k = 0; k < N_READ; k++) begin : g_read
        logic [ADDR_W-1:0] w_raddr;
        logic [DATA_W-1:0] w_rdata;

        assign w_raddr = ADDR_W'(port_field(PORT_BUS_MAX'(bus.read_addr), k, ADDR_W));

        always_comb begin
            w_rdata = '0;
            if (w_ready && (w_raddr != '0)) begin
                if (BYPASS && bus.write_enable && (bus.write_addr == w_raddr)) begin
                    w_rdata = bus.write_data;
                end else begin
                    w_rdata = r_regs[w_raddr];
                end
            end
        end

        assign bus.read_data[k*DATA_W +: DATA_W] = w_rdata;
    end

    assign bus.ready = w_ready;

endmodule
